// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the microsequencer: selector encoding, default address
// width and the well-known microstate addresses (reset, fetch, trap). The
// selector and microstore import the same values.
package ctrl_seq_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [7:0] RESET_ADDR_DEF = 8'd0;
    localparam logic [7:0] FETCH_ADDR_DEF = 8'd1;
    localparam logic [7:0] TRAP_ADDR_DEF  = 8'd255;

    typedef enum logic [1:0] {
        SEL_ENC   = 2'b00,
        SEL_FETCH = 2'b01,
        SEL_PIPE  = 2'b10,
        SEL_INCR  = 2'b11
    } sel_e;

endpackage

// File: rtl/ctrl_ret_stack.sv
// Small LIFO holding microcode return addresses. Push on a full stack is
// dropped, pop on an empty stack leaves it empty; the parent decides what
// those cases mean. Pop has priority when both are requested.
module ctrl_ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == PTR_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign wr_idx  = IDX_W'(sp);
    assign rd_idx  = IDX_W'(sp - PTR_W'(1));
    assign top     = mem[rd_idx];

    // Stack pointer counts occupied entries; reset empties the stack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (do_pop) begin
            sp <= sp - PTR_W'(1);
        end else if (do_push) begin
            sp <= sp + PTR_W'(1);
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/ctrl_addr_seq.sv
// Microsequencer address stage: 4-way next-address mux (encoder, fetch,
// pipeline target, incrementer) feeding the registered state and incrementer
// registers, with stall hold and illegal-opcode trapping.
// Optional return stack enabled by defining USTACK_EN.
module ctrl_addr_seq
    import ctrl_seq_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
    parameter logic [ADDR_W-1:0] FETCH_ADDR = ADDR_W'(FETCH_ADDR_DEF),
    parameter logic [ADDR_W-1:0] TRAP_ADDR  = ADDR_W'(TRAP_ADDR_DEF)
`ifdef USTACK_EN
    , parameter int              STACK_DEPTH = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0,
    input  logic              m1,
    input  logic [ADDR_W-1:0] enc_addr,
    input  logic              enc_valid,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] state_addr,
    output logic [ADDR_W-1:0] incr_addr,
    output logic              illegal,
    output logic              advanced
`ifdef USTACK_EN
    ,
    input  logic              push,
    input  logic              pop,
    output logic              stk_ovf,
    output logic              stk_unf
`endif
);

    sel_e              sel;
    logic [ADDR_W-1:0] nxt;
    logic              trap;

    assign sel = sel_e'({m1, m0});

`ifdef USTACK_EN
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_push;
    logic              stk_pop;

    // The stack only moves on edges where the state itself advances.
    assign stk_push = push && !stall;
    assign stk_pop  = pop && !stall;

    ctrl_ret_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (incr_addr),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );
`endif

    // Next-address mux; a missing decode redirects to the trap microstate.
    always_comb begin
        nxt  = incr_addr;
        trap = 1'b0;
        case (sel)
            SEL_ENC: begin
                if (enc_valid) begin
                    nxt = enc_addr;
                end else begin
                    nxt  = TRAP_ADDR;
                    trap = 1'b1;
                end
            end
            SEL_FETCH: nxt = FETCH_ADDR;
            SEL_PIPE:  nxt = pipe_addr;
            SEL_INCR:  nxt = incr_addr;
            default:   nxt = incr_addr;
        endcase
`ifdef USTACK_EN
        if (pop) begin
            if (stk_empty) begin
                nxt  = TRAP_ADDR;
                trap = 1'b1;
            end else begin
                nxt  = stk_top;
                trap = 1'b0;
            end
        end
`endif
    end

    // State and incrementer registers: RUN loads nxt, HOLD (stall) freezes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_addr <= RESET_ADDR;
            incr_addr  <= RESET_ADDR + ADDR_W'(1);
            illegal    <= 1'b0;
            advanced   <= 1'b0;
        end else if (stall) begin
            illegal    <= 1'b0;
            advanced   <= 1'b0;
        end else begin
            state_addr <= nxt;
            incr_addr  <= nxt + ADDR_W'(1);
            illegal    <= trap;
            advanced   <= 1'b1;
        end
    end

`ifdef USTACK_EN
    // Sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            if (stk_push && !pop && stk_full) begin
                stk_ovf <= 1'b1;
            end
            if (stk_pop && stk_empty) begin
                stk_unf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_addr_seq.sv
// Directed self-checking bench for ctrl_addr_seq. Expected register values are
// queued as each step is driven and compared after the following clock edge.
// Stack steps are included when USTACK_EN is defined.
module tb_ctrl_addr_seq;

    logic       clk;
    logic       rst_n;
    logic       m0;
    logic       m1;
    logic [7:0] enc_addr;
    logic       enc_valid;
    logic [7:0] pipe_addr;
    logic       stall;
    logic [7:0] state_addr;
    logic [7:0] incr_addr;
    logic       illegal;
    logic       advanced;
`ifdef USTACK_EN
    logic       push;
    logic       pop;
    logic       stk_ovf;
    logic       stk_unf;
`endif

    typedef struct {
        string      tag;
        logic [7:0] st;
        logic [7:0] inc;
        logic       ill;
        logic       adv;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    logic exp_ovf;
    logic exp_unf;

    ctrl_addr_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0         (m0),
        .m1         (m1),
        .enc_addr   (enc_addr),
        .enc_valid  (enc_valid),
        .pipe_addr  (pipe_addr),
        .stall      (stall),
        .state_addr (state_addr),
        .incr_addr  (incr_addr),
        .illegal    (illegal),
        .advanced   (advanced)
`ifdef USTACK_EN
        ,
        .push       (push),
        .pop        (pop),
        .stk_ovf    (stk_ovf),
        .stk_unf    (stk_unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (state_addr === e.st) else begin
                bad++;
                $error("[TB] FAIL %s state_addr observed=%h expected=%h", e.tag, state_addr, e.st);
            end
            total++;
            assert (incr_addr === e.inc) else begin
                bad++;
                $error("[TB] FAIL %s incr_addr observed=%h expected=%h", e.tag, incr_addr, e.inc);
            end
            total++;
            assert (illegal === e.ill) else begin
                bad++;
                $error("[TB] FAIL %s illegal observed=%b expected=%b", e.tag, illegal, e.ill);
            end
            total++;
            assert (advanced === e.adv) else begin
                bad++;
                $error("[TB] FAIL %s advanced observed=%b expected=%b", e.tag, advanced, e.adv);
            end
`ifdef USTACK_EN
            total++;
            assert (stk_ovf === e.ovf) else begin
                bad++;
                $error("[TB] FAIL %s stk_ovf observed=%b expected=%b", e.tag, stk_ovf, e.ovf);
            end
            total++;
            assert (stk_unf === e.unf) else begin
                bad++;
                $error("[TB] FAIL %s stk_unf observed=%b expected=%b", e.tag, stk_unf, e.unf);
            end
`endif
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered result, then
    // clock and compare just after the edge.
    task automatic applyStimulus(input string tag, input logic rn, input logic stl,
                                 input logic [1:0] sel, input logic [7:0] ea,
                                 input logic ev, input logic [7:0] pa,
                                 input logic [7:0] est, input logic [7:0] einc,
                                 input logic eill, input logic eadv);
        exp_t e;
        rst_n     = rn;
        stall     = stl;
        m1        = sel[1];
        m0        = sel[0];
        enc_addr  = ea;
        enc_valid = ev;
        pipe_addr = pa;
        e.tag = tag;
        e.st  = est;
        e.inc = einc;
        e.ill = eill;
        e.adv = eadv;
        e.ovf = exp_ovf;
        e.unf = exp_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`ifdef USTACK_EN
        push = 1'b0;
        pop  = 1'b0;
`endif
        #1;
        $display("[TB] starting ctrl_addr_seq directed sequence");

        // Reset wins over stall and a pending pipe selection
        applyStimulus("reset_stall",  1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 8'h40, 8'h00, 8'h01, 1'b0, 1'b0);
        // Fetch then three increments
        applyStimulus("fetch",        1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h40, 8'h01, 8'h02, 1'b0, 1'b1);
        applyStimulus("incr1",        1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h40, 8'h02, 8'h03, 1'b0, 1'b1);
        applyStimulus("incr2",        1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h40, 8'h03, 8'h04, 1'b0, 1'b1);
        applyStimulus("incr3",        1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h40, 8'h04, 8'h05, 1'b0, 1'b1);
        // Encoder path, trap on invalid decode, then silent wrap
        applyStimulus("enc_valid",    1'b1, 1'b0, 2'b00, 8'h23, 1'b1, 8'h40, 8'h23, 8'h24, 1'b0, 1'b1);
        applyStimulus("enc_trap",     1'b1, 1'b0, 2'b00, 8'h23, 1'b0, 8'h40, 8'hFF, 8'h00, 1'b1, 1'b1);
        applyStimulus("wrap",         1'b1, 1'b0, 2'b11, 8'h23, 1'b1, 8'h40, 8'h00, 8'h01, 1'b0, 1'b1);
        // Stall holds state; invalid decode during stall is not a trap
        applyStimulus("stall1",       1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0);
        applyStimulus("stall2",       1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0);
        applyStimulus("stall_notrap", 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0);
        applyStimulus("stall_release",1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 8'h10, 8'h10, 8'h11, 1'b0, 1'b1);
        // Incrementer register wraps before state does
        applyStimulus("enc_fe",       1'b1, 1'b0, 2'b00, 8'hFE, 1'b1, 8'h10, 8'hFE, 8'hFF, 1'b0, 1'b1);
        applyStimulus("incr_ff",      1'b1, 1'b0, 2'b11, 8'hFE, 1'b1, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1);
        applyStimulus("incr_wrap",    1'b1, 1'b0, 2'b11, 8'hFE, 1'b1, 8'h10, 8'h00, 8'h01, 1'b0, 1'b1);
        // Reset overrides a would-be trap
        applyStimulus("reset_trap",   1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0);
        applyStimulus("pipe_80",      1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 8'h80, 8'h80, 8'h81, 1'b0, 1'b1);

`ifdef USTACK_EN
        // Walk to state 0x05, then call into 0x60 saving return 0x06
        applyStimulus("s_fetch",      1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h01, 8'h02, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("s_walk",   1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'(i + 2), 8'(i + 3), 1'b0, 1'b1);
        end
        push = 1'b1;
        applyStimulus("s_call",       1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 8'h60, 8'h60, 8'h61, 1'b0, 1'b1);
        push = 1'b0;
        pop  = 1'b1;
        applyStimulus("s_return",     1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h06, 8'h07, 1'b0, 1'b1);
        pop  = 1'b0;
        // Four pushes fill the stack with 07..0A; the fifth overflows
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("s_fill",   1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'(i + 7), 8'(i + 8), 1'b0, 1'b1);
        end
        exp_ovf = 1'b1;
        applyStimulus("s_overflow",   1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'h0B, 8'h0C, 1'b0, 1'b1);
        // Push together with pop: pop wins, push ignored
        pop  = 1'b1;
        applyStimulus("s_pushpop",    1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'h0A, 8'h0B, 1'b0, 1'b1);
        push = 1'b0;
        applyStimulus("s_pop9",       1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'h09, 8'h0A, 1'b0, 1'b1);
        applyStimulus("s_pop8",       1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'h08, 8'h09, 1'b0, 1'b1);
        applyStimulus("s_pop7",       1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'h07, 8'h08, 1'b0, 1'b1);
        exp_unf = 1'b1;
        applyStimulus("s_underflow",  1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
        pop  = 1'b0;
        applyStimulus("s_sticky",     1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h01, 8'h02, 1'b0, 1'b1);
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        applyStimulus("s_reset",      1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
